axis_byte_packer: RTL and testbench
===================================

// Module: axis_byte_packer
// PURPOSE
//  Upstream stage of axis_processor. Packs an 8-bit AXI-Stream byte stream
//  (host link: UART/USB RX) into PKT_WIDTH-bit instruction packets. Packets
//  drive axis_processor s_axis_*. An idle timeout drops stale partial packets
//  so the host can resynchronise after a lost byte.
// PARAMETERS
//  PKT_WIDTH       24  packet width; equals processor_config::INP_WIDTH
//  TIMEOUT_CYCLES  0   idle cycles before a partial packet is dropped; 0 = never
//  (local) NUM_BYTES = ceil(PKT_WIDTH/8); REM = PKT_WIDTH - 8*(NUM_BYTES-1)
// PORTS
//  clk            in   1          system clock, all logic on rising edge
//  arstn          in   1          async active-low reset
//  s_axis_tdata   in   8          byte from host link
//  s_axis_tvalid  in   1          byte valid
//  s_axis_tready  out  1          packer can accept byte
//  m_axis_tdata   out  PKT_WIDTH  assembled packet
//  m_axis_tvalid  out  1          packet valid
//  m_axis_tready  in   1          downstream accepts packet
//  drop_pulse     out  1          one-cycle pulse when a partial packet is dropped
//  drop_count     out  8          saturating count of dropped partials
// BEHAVIOUR
//  - Reset (async assert, sync release): byte_cnt=0, shift reg=0, idle_cnt=0,
//    m_axis_tvalid=0, m_axis_tdata=0, drop_pulse=0, drop_count=0.
//  - Byte order is MSB first. The first byte of a packet supplies
//    PKT_WIDTH[PKT_WIDTH-1 -: REM] from its low REM bits; its upper 8-REM bits
//    are ignored. Each later byte shifts in below the previous one.
//  - Byte handshake = s_axis_tvalid & s_axis_tready at the rising edge. Each
//    handshake increments byte_cnt (0..NUM_BYTES-1).
//  - Output register: one entry. Packet handshake = m_axis_tvalid & m_axis_tready.
//    m_axis_tdata is stable while m_axis_tvalid=1 and m_axis_tready=0.
//  - Final byte (byte_cnt==NUM_BYTES-1) handshake at edge k: the full packet
//    loads into the output register, m_axis_tvalid=1 after edge k, and byte_cnt
//    returns to 0. Latency is one cycle from the last byte to the valid packet.
//  - s_axis_tready = !(byte_cnt==NUM_BYTES-1 && m_axis_tvalid && !m_axis_tready).
//    Non-final bytes are always accepted. A final byte is accepted in the same
//    cycle that the held packet drains, so sustained throughput is 1 byte/clk.
//  - m_axis_tvalid clears after a packet handshake unless a new packet loads in
//    the same edge. A new load wins, and valid stays 1 with the new data.
//  - Timeout, when TIMEOUT_CYCLES>0: idle_cnt counts each cycle where
//    byte_cnt!=0 and no byte handshake occurs, and it resets to 0 on any byte
//    handshake or when byte_cnt==0. When idle_cnt reaches TIMEOUT_CYCLES-1
//    with no handshake, the next edge sets byte_cnt=0 and idle_cnt=0, pulses
//    drop_pulse for one cycle, and increments drop_count (saturates at 255).
//    A byte arriving on the timeout edge itself counts as a handshake, and the
//    timeout does not fire.
//  - Timeout never affects the output register. A held packet is never dropped.
//  - arstn assert mid-packet or mid-hold discards everything immediately, with
//    no output handshake emitted.
//  - idle_cnt width is $clog2(TIMEOUT_CYCLES+1). With TIMEOUT_CYCLES=0 the
//    timer logic is absent, and drop_pulse and drop_count are held at 0.
// TESTING
//  1 Bytes 84,65,00 back-to-back with m_tready=1 -> one packet 24'h846500, and
//    m_tvalid high exactly 1 cycle after byte 3.
//  2 Stream 84 65 00 20 00 01 94 44 00 20 00 31 with no gaps -> packets
//    846500, 200001, 944400, 200031 in order, and s_tready never drops.
//  3 m_tready=0, send 6 bytes (2 packets) -> 1st packet held stable,
//    s_tready=0 while byte 6 is offered. Raise m_tready -> byte 6 is accepted
//    on the drain edge and the 2nd packet follows with no bubble.
//  4 TIMEOUT_CYCLES=10: send 84,65, idle 10 cycles -> drop_pulse once,
//    drop_count=1. Then 20,00,01 -> packet 200001. Repeat the test with the
//    3rd byte on idle cycle 10 exactly -> no drop.
//  5 PKT_WIDTH=16 (NUM_BYTES=2): 60,00 -> 16'h6000. PKT_WIDTH=12: FA,BC ->
//    12'hABC, with the upper nibble of the first byte ignored.
//  6 Assert arstn after 2 bytes, and separately while a packet is held ->
//    outputs at reset values; the next 3 bytes form a clean packet.

Source files
------------

// File: rtl/axis_byte_packer.sv
// Packs an MSB-first 8-bit AXI-Stream into PKT_WIDTH-bit packets held in a
// one-entry output register, with an optional idle timeout for partial packets.
module axis_byte_packer #(
    parameter int PKT_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [PKT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 drop_pulse,
    output logic [7:0]           drop_count
);
    localparam int NUM_BYTES = (PKT_WIDTH + 7) / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [PKT_WIDTH-1:0] shift_q, shift_d;
    logic [PKT_WIDTH-1:0] pkt_data_q, pkt_data_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic [PKT_WIDTH-1:0] shift_base;
    logic [PKT_WIDTH-1:0] shift_next;
    logic                 last_byte;
    logic                 byte_hs;
    logic                 pkt_hs;
    logic                 load;
    logic                 timeout_fire;

    assign last_byte     = (byte_cnt_q == LAST_IDX);
    assign s_axis_tready = !(last_byte && pkt_valid_q && !m_axis_tready);
    assign byte_hs       = s_axis_tvalid && s_axis_tready;
    assign pkt_hs        = pkt_valid_q && m_axis_tready;
    assign load          = byte_hs && last_byte;

    // Truncating to PKT_WIDTH after NUM_BYTES shifts discards the unused
    // upper bits of the first byte without any special casing.
    assign shift_base = (byte_cnt_q == '0) ? '0 : shift_q;
    assign shift_next = PKT_WIDTH'({shift_base, s_axis_tdata});

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        if (load) begin
            byte_cnt_d  = '0;
            shift_d     = '0;
            pkt_data_d  = shift_next;
            pkt_valid_d = 1'b1;
        end else begin
            if (pkt_hs) begin
                pkt_valid_d = 1'b0;
            end
            if (byte_hs) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                shift_d    = shift_next;
            end else if (timeout_fire) begin
                byte_cnt_d = '0;
                shift_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

    assign m_axis_tdata  = pkt_data_q;
    assign m_axis_tvalid = pkt_valid_q;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

            logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
            logic              drop_pulse_q, drop_pulse_d;
            logic [7:0]        drop_count_q, drop_count_d;

            // A byte on the would-be timeout edge wins over the drop.
            always_comb begin
                timeout_fire = (byte_cnt_q != '0) && !byte_hs && (idle_cnt_q == IDLE_LAST);
                idle_cnt_d   = idle_cnt_q + IDLE_W'(1);
                if (byte_hs || (byte_cnt_q == '0) || timeout_fire) begin
                    idle_cnt_d = '0;
                end
                drop_pulse_d = timeout_fire;
                drop_count_d = drop_count_q;
                if (timeout_fire && (drop_count_q != 8'hFF)) begin
                    drop_count_d = drop_count_q + 8'd1;
                end
            end

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn) begin
                    idle_cnt_q   <= '0;
                    drop_pulse_q <= 1'b0;
                    drop_count_q <= 8'd0;
                end else begin
                    idle_cnt_q   <= idle_cnt_d;
                    drop_pulse_q <= drop_pulse_d;
                    drop_count_q <= drop_count_d;
                end
            end

            assign drop_pulse = drop_pulse_q;
            assign drop_count = drop_count_q;
        end else begin : g_no_timer
            assign timeout_fire = 1'b0;
            assign drop_pulse   = 1'b0;
            assign drop_count   = 8'd0;
        end
    endgenerate

endmodule

// File: tb/tb_axis_byte_packer.sv
// Randomized and directed bench: a 24-bit packer with a 10-cycle timeout,
// plus 16-bit and 12-bit packers without timeout, all against a queue model.
module tb_axis_byte_packer;
    localparam int TO = 10;
    localparam int NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic arstn;

    logic [7:0]  a_s_data;
    logic        a_s_valid, a_s_ready;
    logic [23:0] a_m_data;
    logic        a_m_valid, a_m_ready;
    logic        a_drop_pulse;
    logic [7:0]  a_drop_count;

    logic [7:0]  bc_s_data;
    logic        bc_s_valid, bc_m_ready;
    logic        b_s_ready, c_s_ready;
    logic [15:0] b_m_data;
    logic [11:0] c_m_data;
    logic        b_m_valid, c_m_valid;
    logic        b_drop_pulse, c_drop_pulse;
    logic [7:0]  b_drop_count, c_drop_count;

    axis_byte_packer #(.PKT_WIDTH(24), .TIMEOUT_CYCLES(TO)) u_a (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(a_s_data), .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready),
        .m_axis_tdata(a_m_data), .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
        .drop_pulse(a_drop_pulse), .drop_count(a_drop_count));

    axis_byte_packer #(.PKT_WIDTH(16), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(bc_s_data), .s_axis_tvalid(bc_s_valid), .s_axis_tready(b_s_ready),
        .m_axis_tdata(b_m_data), .m_axis_tvalid(b_m_valid), .m_axis_tready(bc_m_ready),
        .drop_pulse(b_drop_pulse), .drop_count(b_drop_count));

    axis_byte_packer #(.PKT_WIDTH(12), .TIMEOUT_CYCLES(0)) u_c (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(bc_s_data), .s_axis_tvalid(bc_s_valid), .s_axis_tready(c_s_ready),
        .m_axis_tdata(c_m_data), .m_axis_tvalid(c_m_valid), .m_axis_tready(bc_m_ready),
        .drop_pulse(c_drop_pulse), .drop_count(c_drop_count));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for the 24-bit packer
    logic [7:0]  mdl_part[$];
    int          mdl_idle = 0;
    bit          mdl_held = 0;
    bit          mdl_pulse = 0;
    int          mdl_cnt = 0;
    int          ready_pct = 100;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_c[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Concatenate bytes MSB first and keep the low w bits.
    function automatic logic [31:0] pack(input logic [7:0] q[$], input int w);
        logic [63:0] p;
        p = 64'd0;
        foreach (q[i]) p = (p << 8) | 64'(q[i]);
        p = p & ((64'd1 << w) - 64'd1);
        return p[31:0];
    endfunction

    function automatic logic rand_ready();
        return ($urandom_range(99) < ready_pct);
    endfunction

    // One clock cycle on the 24-bit packer; entered and left at posedge+1.
    task automatic step(input logic v, input logic [7:0] d, input logic mr, output logic hs);
        bit rdy, load, drop, held_n;
        a_s_valid = v;
        a_s_data  = d;
        a_m_ready = mr;
        #1;
        rdy = !((mdl_part.size() == NB - 1) && mdl_held && !mr);
        check("s_tready", a_s_ready, rdy);
        hs = v && rdy;
        load = 0;
        drop = 0;
        if (hs) begin
            mdl_part.push_back(d);
            mdl_idle = 0;
            if (mdl_part.size() == NB) begin
                exp_a.push_back(pack(mdl_part, 24));
                mdl_part.delete();
                load = 1;
            end
        end else if (mdl_part.size() != 0) begin
            mdl_idle++;
            if (mdl_idle == TO) begin
                drop = 1;
                mdl_part.delete();
                mdl_idle = 0;
            end
        end else begin
            mdl_idle = 0;
        end
        held_n = load ? 1'b1 : ((mdl_held && mr) ? 1'b0 : mdl_held);
        @(posedge clk);
        mdl_held  = held_n;
        mdl_pulse = drop;
        if (drop && mdl_cnt < 255) mdl_cnt++;
        #1;
    endtask

    task automatic idle(input int n);
        logic hs;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rand_ready(), hs);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic hs;
        int n;
        idle(gap);
        hs = 1'b0;
        n = 0;
        while (!hs && n < 200) begin
            step(1'b1, b, rand_ready(), hs);
            n++;
        end
        if (!hs) check("byte_accept_bound", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        arstn      = 1'b0;
        a_s_valid  = 1'b0;
        bc_s_valid = 1'b0;
        mdl_part.delete();
        mdl_idle  = 0;
        mdl_held  = 0;
        mdl_pulse = 0;
        mdl_cnt   = 0;
        exp_a.delete();
        #1;
        check("rst_m_tvalid", a_m_valid, 32'd0);
        check("rst_m_tdata", a_m_data, 32'd0);
        check("rst_drop_pulse", a_drop_pulse, 32'd0);
        check("rst_drop_count", a_drop_count, 32'd0);
        check("rst_s_tready", a_s_ready, 32'd1);
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
    endtask

    // Monitor for the 24-bit packer
    bit          prev_stall = 0;
    logic [23:0] prev_data;
    always @(negedge clk) begin
        if (!arstn) begin
            prev_stall = 0;
        end else begin
            check("m_tvalid", a_m_valid, mdl_held);
            check("drop_pulse", a_drop_pulse, mdl_pulse);
            check("drop_count", a_drop_count, mdl_cnt);
            if (prev_stall) check("hold_stable", a_m_data, prev_data);
            if (a_m_valid && a_m_ready) begin
                if (exp_a.size() == 0) check("a_unexpected_packet", a_m_data, 32'hDEAD_BEEF);
                else check("a_packet", a_m_data, exp_a.pop_front());
            end
            prev_stall = a_m_valid && !a_m_ready;
            prev_data  = a_m_data;
        end
    end

    // Monitor for the 16-bit and 12-bit packers (always ready downstream)
    always @(negedge clk) begin
        if (arstn) begin
            check("b_s_tready", b_s_ready, 32'd1);
            check("c_s_tready", c_s_ready, 32'd1);
            check("b_drop", {b_drop_pulse, b_drop_count}, 32'd0);
            check("c_drop", {c_drop_pulse, c_drop_count}, 32'd0);
            if (b_m_valid) begin
                if (exp_b.size() == 0) check("b_unexpected_packet", b_m_data, 32'hDEAD_BEEF);
                else check("b_packet", b_m_data, exp_b.pop_front());
            end
            if (c_m_valid) begin
                if (exp_c.size() == 0) check("c_unexpected_packet", c_m_data, 32'hDEAD_BEEF);
                else check("c_packet", c_m_data, exp_c.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        logic [7:0] x, y;
        logic [7:0] stream[12];
        int gap;

        a_s_valid  = 1'b0;
        a_s_data   = 8'h00;
        a_m_ready  = 1'b1;
        bc_s_valid = 1'b0;
        bc_s_data  = 8'h00;
        bc_m_ready = 1'b1;
        apply_reset();

        // Narrow packers: directed pairs first, then random
        for (int k = 0; k < 14; k++) begin
            if (k == 0) begin x = 8'h60; y = 8'h00; end
            else if (k == 1) begin x = 8'hFA; y = 8'hBC; end
            else begin x = 8'($urandom); y = 8'($urandom); end
            bq = {x, y};
            exp_b.push_back(pack(bq, 16));
            exp_c.push_back(pack(bq, 12));
            bc_s_valid = 1'b1;
            bc_s_data  = x;
            @(posedge clk);
            #1 bc_s_data = y;
            @(posedge clk);
            #1 bc_s_valid = 1'b0;
            repeat ($urandom_range(2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("b_queue_drained", exp_b.size(), 32'd0);
        check("c_queue_drained", exp_c.size(), 32'd0);

        // Single packet, back to back, latency one cycle
        ready_pct = 100;
        send_byte(8'h84, 0);
        send_byte(8'h65, 0);
        send_byte(8'h00, 0);
        idle(3);

        // Gapless stream of four packets
        stream = '{8'h84, 8'h65, 8'h00, 8'h20, 8'h00, 8'h01,
                   8'h94, 8'h44, 8'h00, 8'h20, 8'h00, 8'h31};
        foreach (stream[i]) send_byte(stream[i], 0);
        idle(3);

        // Backpressure: first packet held, final byte of second stalls
        ready_pct = 0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        begin
            logic hs;
            for (int i = 0; i < 3; i++) step(1'b1, 8'h06, 1'b0, hs);
        end
        ready_pct = 100;
        send_byte(8'h06, 0);
        idle(4);

        // Timeout drop, recovery, and the byte-on-timeout-edge case
        send_byte(8'h84, 0);
        send_byte(8'h65, 0);
        idle(10);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        idle(3);
        send_byte(8'h84, 0);
        send_byte(8'h65, 0);
        send_byte(8'h00, 9);
        idle(3);

        // Reset mid-packet and while a packet is held
        send_byte(8'h84, 0);
        send_byte(8'h65, 0);
        apply_reset();
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        idle(2);
        ready_pct = 0;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        idle(2);
        apply_reset();
        ready_pct = 100;
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        idle(3);

        // Random traffic with random backpressure and occasional long gaps
        ready_pct = 60;
        for (int i = 0; i < 120; i++) begin
            gap = ($urandom_range(7) == 0) ? 11 : int'($urandom_range(3));
            send_byte(8'($urandom), gap);
        end
        ready_pct = 100;
        idle(20);
        check("a_queue_drained", exp_a.size(), 32'd0);
        check("partial_flushed", mdl_part.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
